// File: rtl/md_sequencer_if.sv
// Request and shared-adder signal bundle for md_sequencer; the sequencer takes the slave side,
// the datapath (requester plus the external 32-bit adder) takes the master side.
interface md_sequencer_if #(
   parameter int WIDTH = 32
);
   logic             START;
   logic             OP_DIV;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             BUSY;
   logic             DONE;
   logic             DZ;
   logic [WIDTH-1:0] HI;
   logic [WIDTH-1:0] LO;
   logic [WIDTH-1:0] ADD_A;
   logic [WIDTH-1:0] ADD_B;
   logic             ADD_OP;
   logic             ADD_C0;
   logic [WIDTH-1:0] ADD_S;
   logic             ADD_C;

   modport master (
      output START, OP_DIV, A, B, ADD_S, ADD_C,
      input  BUSY, DONE, DZ, HI, LO, ADD_A, ADD_B, ADD_OP, ADD_C0
   );

   modport slave (
      input  START, OP_DIV, A, B, ADD_S, ADD_C,
      output BUSY, DONE, DZ, HI, LO, ADD_A, ADD_B, ADD_OP, ADD_C0
   );
endinterface

// File: rtl/md_sequencer.sv
// MULTU/DIVU sequencer: shift-add multiply and restoring divide through an external adder into HI/LO.
// Optional MD_DIV0_FAST_EN: divide by zero finishes straight from IDLE instead of iterating.
module md_sequencer #(
   parameter int WIDTH = 32
) (
   input  logic           CLK,
   input  logic           RST,
   md_sequencer_if.slave  bus
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      S_IDLE,
      S_MUL,
      S_DIV,
      S_DONE
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic [WIDTH-1:0] m_q, m_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             dz_q, dz_d;

   logic [WIDTH-1:0] add_a, add_b;
   logic             add_op, add_c0;
   logic             last_iter;
   logic             sub_ok;
   logic             fast_div0;

   assign last_iter = (cnt_q == CW'(WIDTH - 1));
   // The bit shifted out of HI makes the partial remainder exceed any 32-bit divisor.
   assign sub_ok    = hi_q[WIDTH-1] | bus.ADD_C;

`ifdef MD_DIV0_FAST_EN
   assign fast_div0 = bus.OP_DIV && (bus.B == '0);
`else
   assign fast_div0 = 1'b0;
`endif

   always_comb begin
      add_a  = '0;
      add_b  = '0;
      add_op = 1'b0;
      add_c0 = 1'b0;
      case (state_q)
         S_MUL: begin
            add_a = hi_q;
            add_b = m_q;
         end
         S_DIV: begin
            add_a  = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
            add_b  = m_q;
            add_op = 1'b1;
            add_c0 = 1'b1;
         end
         default: begin
         end
      endcase
   end

   always_comb begin
      state_d = state_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      m_d     = m_q;
      cnt_d   = cnt_q;
      dz_d    = dz_q;
      case (state_q)
         S_IDLE: begin
            if (bus.START) begin
               hi_d  = '0;
               cnt_d = '0;
               dz_d  = 1'b0;
               if (fast_div0) begin
                  state_d = S_DONE;
                  hi_d    = bus.A;
                  lo_d    = '1;
                  m_d     = '0;
                  dz_d    = 1'b1;
               end else if (bus.OP_DIV) begin
                  state_d = S_DIV;
                  lo_d    = bus.A;
                  m_d     = bus.B;
               end else begin
                  state_d = S_MUL;
                  lo_d    = bus.B;
                  m_d     = bus.A;
               end
            end
         end
         S_MUL: begin
            cnt_d = cnt_q + CW'(1);
            if (lo_q[0]) begin
               hi_d = {bus.ADD_C, bus.ADD_S[WIDTH-1:1]};
               lo_d = {bus.ADD_S[0], lo_q[WIDTH-1:1]};
            end else begin
               hi_d = {1'b0, hi_q[WIDTH-1:1]};
               lo_d = {hi_q[0], lo_q[WIDTH-1:1]};
            end
            if (last_iter) begin
               state_d = S_DONE;
            end
         end
         S_DIV: begin
            cnt_d = cnt_q + CW'(1);
            if (m_q == '0) begin
               dz_d = 1'b1;
            end
            if (sub_ok) begin
               hi_d = bus.ADD_S;
               lo_d = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
               hi_d = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
               lo_d = {lo_q[WIDTH-2:0], 1'b0};
            end
            if (last_iter) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      busy_d = (state_d != S_IDLE);
      done_d = (state_d == S_DONE);
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= S_IDLE;
         hi_q    <= '0;
         lo_q    <= '0;
         m_q     <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         dz_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         m_q     <= m_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         dz_q    <= dz_d;
      end
   end

   assign bus.BUSY   = busy_q;
   assign bus.DONE   = done_q;
   assign bus.DZ     = dz_q;
   assign bus.HI     = hi_q;
   assign bus.LO     = lo_q;
   assign bus.ADD_A  = add_a;
   assign bus.ADD_B  = add_b;
   assign bus.ADD_OP = add_op;
   assign bus.ADD_C0 = add_c0;

endmodule

// File: tb/tb_md_sequencer.sv
// Scoreboard bench for md_sequencer: directed MULTU/DIVU vectors, START-while-busy and reset abort.
// The external adder is modelled here; build with MD_DIV0_FAST_EN to expect the fast divide-by-zero path.
module tb_md_sequencer;

   logic CLK = 1'b0;
   logic RST = 1'b1;

   md_sequencer_if bus ();

   md_sequencer dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus.slave)
   );

   always #5 CLK = ~CLK;

   // External 32-bit adder/subtractor that the sequencer drives.
   assign {bus.ADD_C, bus.ADD_S} = {1'b0, bus.ADD_A}
                                 + {1'b0, (bus.ADD_OP ? ~bus.ADD_B : bus.ADD_B)}
                                 + {32'd0, bus.ADD_C0};

`ifdef MD_DIV0_FAST_EN
   localparam int DIV0_LAT = 1;
`else
   localparam int DIV0_LAT = 33;
`endif

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dz;
      int          s0;
      int          lat;
      string       name;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   cyc    = 0;
   int   passed = 0;
   int   total  = 0;
   int   s0;
   int   s1;

   always @(posedge CLK) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act === req) begin
         passed++;
      end else begin
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
      end
   endtask

   // Drives one START pulse at a negedge; s0 is cycle 0 (the period whose closing edge accepts START).
   task automatic applyStimulus(input logic op, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] hi, input logic [31:0] lo, input logic dz,
                                input int lat, input string name, input bit push, output int st);
      @(negedge CLK);
      bus.START  = 1'b1;
      bus.OP_DIV = op;
      bus.A      = a;
      bus.B      = b;
      @(posedge CLK);
      #1;
      st = cyc - 1;
      if (push) begin
         sb.push_back('{hi, lo, dz, st, lat, name});
      end
      bus.START  = 1'b0;
      bus.OP_DIV = 1'($urandom);
      bus.A      = $urandom;
      bus.B      = $urandom;
   endtask

   task automatic waitIdle(input string name);
      int n = 0;
      while ((sb.size() != 0 || bus.BUSY !== 1'b0) && n < 200) begin
         @(negedge CLK);
         n++;
      end
      checkOutput({name, " completes"}, 32'(sb.size()), 32'd0);
   endtask

   always @(negedge CLK) begin
      if (!RST && bus.DONE === 1'b1) begin
         if (sb.size() == 0) begin
            checkOutput("DONE without pending op", {31'd0, bus.DONE}, 32'd0);
         end else begin
            mon_e = sb.pop_front();
            checkOutput({mon_e.name, " HI"}, bus.HI, mon_e.hi);
            checkOutput({mon_e.name, " LO"}, bus.LO, mon_e.lo);
            checkOutput({mon_e.name, " DZ"}, {31'd0, bus.DZ}, {31'd0, mon_e.dz});
            checkOutput({mon_e.name, " latency"}, 32'(cyc - mon_e.s0), 32'(mon_e.lat));
         end
      end
   end

   initial begin
      bus.START  = 1'b0;
      bus.OP_DIV = 1'b0;
      bus.A      = '0;
      bus.B      = '0;

      repeat (3) @(negedge CLK);
      checkOutput("reset HI", bus.HI, 32'd0);
      checkOutput("reset LO", bus.LO, 32'd0);
      checkOutput("reset BUSY", {31'd0, bus.BUSY}, 32'd0);
      checkOutput("reset DONE", {31'd0, bus.DONE}, 32'd0);
      checkOutput("reset DZ", {31'd0, bus.DZ}, 32'd0);
      checkOutput("reset ADD_OP", {31'd0, bus.ADD_OP}, 32'd0);
      RST = 1'b0;
      repeat (2) @(negedge CLK);

      applyStimulus(1'b0, 32'd7, 32'd6, 32'd0, 32'd42, 1'b0, 33, "mul 7x6", 1'b1, s0);
      while (cyc < s0 + 34) begin
         @(negedge CLK);
         if (cyc == s0 + 1) begin
            checkOutput("mul BUSY cycle 1", {31'd0, bus.BUSY}, 32'd1);
            checkOutput("mul ADD_B", bus.ADD_B, 32'd7);
            checkOutput("mul ADD_OP", {31'd0, bus.ADD_OP}, 32'd0);
         end
         if (cyc == s0 + 33) begin
            checkOutput("mul BUSY cycle 33", {31'd0, bus.BUSY}, 32'd1);
         end
         if (cyc == s0 + 34) begin
            checkOutput("mul BUSY cycle 34", {31'd0, bus.BUSY}, 32'd0);
            checkOutput("idle ADD_A", bus.ADD_A, 32'd0);
            checkOutput("idle LO hold", bus.LO, 32'd42);
         end
      end
      waitIdle("mul 7x6");

      applyStimulus(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 33,
                    "mul max", 1'b1, s0);
      waitIdle("mul max");

      applyStimulus(1'b1, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 33, "div 100/7", 1'b1, s0);
      @(negedge CLK);
      checkOutput("div ADD_OP", {31'd0, bus.ADD_OP}, 32'd1);
      checkOutput("div ADD_C0", {31'd0, bus.ADD_C0}, 32'd1);
      checkOutput("div ADD_B", bus.ADD_B, 32'd7);
      waitIdle("div 100/7");

      applyStimulus(1'b1, 32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE, 32'd1, 1'b0, 33,
                    "div hi31", 1'b1, s0);
      waitIdle("div hi31");

      applyStimulus(1'b1, 32'd1234, 32'd0, 32'd1234, 32'hFFFF_FFFF, 1'b1, DIV0_LAT,
                    "div 1234/0", 1'b1, s0);
      waitIdle("div 1234/0");
      repeat (3) @(negedge CLK);
      checkOutput("idle DZ hold", {31'd0, bus.DZ}, 32'd1);
      checkOutput("idle HI hold", bus.HI, 32'd1234);

      applyStimulus(1'b0, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0, 33, "mul 3x5 restart", 1'b1, s0);
      while (cyc < s0 + 33) begin
         @(negedge CLK);
         if (cyc == s0 + 5) begin
            bus.START  = 1'b1;
            bus.OP_DIV = 1'b1;
            bus.A      = 32'd8;
            bus.B      = 32'd0;
         end
         if (cyc == s0 + 6) begin
            bus.START = 1'b0;
         end
         if (cyc == s0 + 33) begin
            bus.START  = 1'b1;
            bus.OP_DIV = 1'b1;
            bus.A      = 32'd9;
            bus.B      = 32'd2;
         end
      end
      applyStimulus(1'b1, 32'd9, 32'd2, 32'd1, 32'd4, 1'b0, 33, "div 9/2 after done", 1'b1, s1);
      checkOutput("start accepted cycle 34", 32'(s1 - s0), 32'd34);
      waitIdle("div 9/2 after done");

      applyStimulus(1'b1, 32'd1000, 32'd3, 32'd0, 32'd0, 1'b0, 33, "div abort", 1'b0, s0);
      while (cyc < s0 + 10) @(negedge CLK);
      RST = 1'b1;
      #1;
      checkOutput("abort HI", bus.HI, 32'd0);
      checkOutput("abort LO", bus.LO, 32'd0);
      checkOutput("abort BUSY", {31'd0, bus.BUSY}, 32'd0);
      checkOutput("abort DZ", {31'd0, bus.DZ}, 32'd0);
      @(negedge CLK);
      RST = 1'b0;
      repeat (40) @(negedge CLK);
      waitIdle("div abort");

      applyStimulus(1'b0, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0, 33, "mul 2x3", 1'b1, s0);
      waitIdle("mul 2x3");

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
